// File: rtl/stream_upsizer.sv
// Packs RATIO narrow words from an upstream FWFT FIFO into one wide word (first word in LSBs)
// and writes it into a downstream FIFO/relay station. Full throughput, one-word HOLD slot.
module stream_upsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_empty_n,
  input  logic [IN_WIDTH-1:0]  in_dout,
  output logic                 in_read,
  input  logic                 out_full_n,
  output logic                 out_write,
  output logic [OUT_WIDTH-1:0] out_din,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  logic [OUT_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 pend_q;
  logic                 acc;
  logic                 last_acc;

  // Handshake is combinational; out_full_n -> in_read is deliberate so a completed word
  // can leave in the same cycle the next lane is accepted. Outputs are forced idle in reset.
  always_comb begin
    in_read   = reset_n & in_empty_n & (~pend_q | out_full_n);
    out_write = reset_n & pend_q & out_full_n;
    out_din   = reset_n ? data_q : '0;
    busy      = reset_n & ((cnt_q != '0) | pend_q);
    acc       = in_empty_n & in_read;
    last_acc  = acc & (cnt_q == LAST_LANE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees the
  // pre-edge values of its neighbours; the data buffer is reset too because out_din must read 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (acc) begin
        for (int i = 0; i < RATIO; i++) begin
          if (cnt_q == CNT_WIDTH'(i)) data_q[i*IN_WIDTH +: IN_WIDTH] <= in_dout;
        end
        cnt_q <= (cnt_q == LAST_LANE) ? '0 : cnt_q + CNT_WIDTH'(1);
      end
      // A completing lane wins over a concurrent write: the slot is refilled at once.
      if (last_acc)       pend_q <= 1'b1;
      else if (out_write) pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: RATIO=4 and RATIO=1 instances checked cycle by cycle against a
// queue-based packing model; directed scenarios plus random traffic.
module tb_stream_upsizer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_empty_n, out_full_n, in_read, out_write, busy;
  logic [31:0]  in_dout;
  logic [127:0] out_din;

  logic         r1_empty_n, r1_full_n, r1_read, r1_write, r1_busy;
  logic [31:0]  r1_dout, r1_din;

  int checks = 0;
  int errors = 0;

  // Reference model for the RATIO=4 instance
  logic [31:0]  part_q[$];
  logic [127:0] pend_word;
  bit           pend_valid;

  always #5 clk = ~clk;

  stream_upsizer #(.IN_WIDTH(32), .RATIO(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_empty_n(in_empty_n), .in_dout(in_dout),
    .in_read(in_read), .out_full_n(out_full_n), .out_write(out_write),
    .out_din(out_din), .busy(busy)
  );

  stream_upsizer #(.IN_WIDTH(32), .RATIO(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_empty_n(r1_empty_n), .in_dout(r1_dout),
    .in_read(r1_read), .out_full_n(r1_full_n), .out_write(r1_write),
    .out_din(r1_din), .busy(r1_busy)
  );

  // One clock of the RATIO=4 instance: drive, compare at negedge, update model, advance.
  task automatic step(input bit rst_n, input bit v, input logic [31:0] d, input bit fn,
                      output bit rd, output bit wr, output logic [127:0] din);
    bit exp_rd, exp_wr, exp_busy;
    reset_n    = rst_n;
    in_empty_n = v;
    in_dout    = d;
    out_full_n = fn;
    @(negedge clk);
    exp_rd   = rst_n && v && (!pend_valid || fn);
    exp_wr   = rst_n && pend_valid && fn;
    exp_busy = rst_n && (part_q.size() != 0 || pend_valid);
    checks += 3;
    if (in_read !== exp_rd) begin
      errors++; $display("FAIL in_read: got %b expected %b", in_read, exp_rd);
    end
    if (out_write !== exp_wr) begin
      errors++; $display("FAIL out_write: got %b expected %b", out_write, exp_wr);
    end
    if (busy !== exp_busy) begin
      errors++; $display("FAIL busy: got %b expected %b", busy, exp_busy);
    end
    if (exp_wr) begin
      checks++;
      if (out_din !== pend_word) begin
        errors++; $display("FAIL out_din: got %h expected %h", out_din, pend_word);
      end
    end
    if (!rst_n) begin
      checks++;
      if (out_din !== '0) begin
        errors++; $display("FAIL reset_out_din: got %h expected 0", out_din);
      end
    end
    rd  = in_read;
    wr  = out_write;
    din = out_din;
    if (!rst_n) begin
      part_q.delete();
      pend_valid = 1'b0;
    end else begin
      if (exp_wr) pend_valid = 1'b0;
      if (exp_rd) begin
        part_q.push_back(d);
        if (part_q.size() == 4) begin
          pend_word  = {part_q[3], part_q[2], part_q[1], part_q[0]};
          pend_valid = 1'b1;
          part_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit rd, wr;
    logic [127:0] din;
    step(1'b0, 1'b1, $urandom, 1'b1, rd, wr, din);
    step(1'b0, 1'b0, 32'h0, 1'b1, rd, wr, din);
  endtask

  task automatic test_reset();
    bit rd, wr;
    logic [127:0] din;
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1, rd, wr, din);
    checks += 2;
    if (busy !== 1'b0 || out_din !== '0) begin
      errors++; $display("FAIL reset_state: busy %b out_din %h expected 0/0", busy, out_din);
    end
    if (r1_busy !== 1'b0 || r1_din !== '0) begin
      errors++; $display("FAIL reset_state_r1: busy %b out_din %h expected 0/0", r1_busy, r1_din);
    end
  endtask

  task automatic test_basic_pack();
    bit rd, wr;
    logic [127:0] din, got;
    int writes = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, i, 1'b1, rd, wr, din);
      if (wr) writes++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, rd, wr, din);
    got = din;
    checks += 3;
    if (writes != 0) begin
      errors++; $display("FAIL t1_early_write: got %0d writes expected 0", writes);
    end
    if (wr !== 1'b1) begin
      errors++; $display("FAIL t1_latency: got out_write %b expected 1", wr);
    end
    if (got !== 128'h00000004_00000003_00000002_00000001) begin
      errors++; $display("FAIL t1_word: got %h expected 00000004000000030000000200000001", got);
    end
  endtask

  task automatic test_back_to_back();
    bit rd, wr;
    logic [127:0] din;
    int reads = 0, writes = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, $urandom, 1'b1, rd, wr, din);
      if (rd) reads++;
      if (wr) writes++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, rd, wr, din);
    if (wr) writes++;
    checks += 2;
    if (reads != 16) begin
      errors++; $display("FAIL t2_reads: got %0d expected 16", reads);
    end
    if (writes != 4) begin
      errors++; $display("FAIL t2_writes: got %0d expected 4", writes);
    end
  endtask

  task automatic test_backpressure();
    bit rd, wr;
    logic [127:0] din, word;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, 1'b1, rd, wr, din);
    word = pend_word;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, $urandom, 1'b0, rd, wr, din);
      checks++;
      if (out_din !== word) begin
        errors++; $display("FAIL t3_hold_din: got %h expected %h", out_din, word);
      end
    end
    step(1'b1, 1'b1, 32'h5a5a_0001, 1'b1, rd, wr, din);
    checks++;
    if (!(rd && wr) || din !== word) begin
      errors++; $display("FAIL t3_release: got rd %b wr %b din %h expected 1 1 %h", rd, wr, din, word);
    end
  endtask

  task automatic test_gaps();
    bit rd, wr;
    logic [127:0] din;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, (i % 2) == 0, $urandom, 1'b1, rd, wr, din);
    step(1'b1, 1'b1, $urandom, 1'b1, rd, wr, din);
    step(1'b1, 1'b0, 32'h0, 1'b1, rd, wr, din);
  endtask

  task automatic test_reset_midword();
    bit rd, wr;
    logic [127:0] din, got;
    logic [31:0] w[4];
    int writes = 0;
    do_reset();
    step(1'b1, 1'b1, 32'hdead_0001, 1'b1, rd, wr, din);
    step(1'b1, 1'b1, 32'hdead_0002, 1'b1, rd, wr, din);
    step(1'b0, 1'b1, 32'hdead_0003, 1'b1, rd, wr, din);
    got = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      step(1'b1, 1'b1, w[i], 1'b1, rd, wr, din);
      if (wr) writes++;
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, rd, wr, din);
    if (wr) begin writes++; got = din; end
    checks += 2;
    if (writes != 1) begin
      errors++; $display("FAIL t5_writes: got %0d expected 1", writes);
    end
    if (got !== {w[3], w[2], w[1], w[0]}) begin
      errors++; $display("FAIL t5_word: got %h expected %h", got, {w[3], w[2], w[1], w[0]});
    end
  endtask

  task automatic test_random();
    bit rd, wr;
    logic [127:0] din;
    do_reset();
    for (int i = 0; i < 300; i++)
      step(1'b1, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, rd, wr, din);
  endtask

  task automatic test_ratio1();
    logic [31:0] got_q[$];
    bit pend = 1'b0;
    int next = 0;
    int cycles = 0;
    bit exp_rd, exp_wr, fn;
    while ((next < 10 || pend) && cycles < 400) begin
      fn         = $urandom_range(0, 1);
      r1_empty_n = (next < 10);
      r1_dout    = next;
      r1_full_n  = fn;
      @(negedge clk);
      exp_rd = (next < 10) && (!pend || fn);
      exp_wr = pend && fn;
      checks += 2;
      if (r1_read !== exp_rd) begin
        errors++; $display("FAIL t6_in_read: got %b expected %b", r1_read, exp_rd);
      end
      if (r1_write !== exp_wr) begin
        errors++; $display("FAIL t6_out_write: got %b expected %b", r1_write, exp_wr);
      end
      if (r1_write) got_q.push_back(r1_din);
      if (exp_wr) pend = 1'b0;
      if (exp_rd) begin pend = 1'b1; next++; end
      @(posedge clk);
      #1;
      cycles++;
    end
    r1_empty_n = 1'b0;
    r1_full_n  = 1'b1;
    checks++;
    if (cycles >= 400) begin
      errors++; $display("FAIL t6_timeout: got %0d cycles expected < 400", cycles);
    end
    checks++;
    if (got_q.size() != 10) begin
      errors++; $display("FAIL t6_count: got %0d expected 10", got_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got_q[i] !== i) begin
          errors++; $display("FAIL t6_order[%0d]: got %0d expected %0d", i, got_q[i], i);
        end
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    in_empty_n = 1'b0;
    in_dout    = '0;
    out_full_n = 1'b1;
    r1_empty_n = 1'b0;
    r1_dout    = '0;
    r1_full_n  = 1'b1;
    pend_valid = 1'b0;
    pend_word  = '0;
    test_reset();
    test_basic_pack();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_reset_midword();
    test_random();
    test_ratio1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
